// File: rtl/imem_port_arbiter_if.sv
// Bundle of fetch, loader and instruction-memory signals around the imem port arbiter.
// The arbiter takes the slave view; requesters and the memory model take the master view.
interface imem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_gnt;
  logic              f_rvalid;
  logic [DATA_W-1:0] f_rdata;
  logic              f_err;

  logic              l_req;
  logic              l_we;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic              l_lock;
  logic              l_gnt;
  logic              l_rvalid;
  logic [DATA_W-1:0] l_rdata;
  logic              l_err;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [1:0]        owner;

  modport master (
    output f_req, f_addr, l_req, l_we, l_addr, l_wdata, l_lock, mem_rdata,
    input  f_gnt, f_rvalid, f_rdata, f_err, l_gnt, l_rvalid, l_rdata, l_err,
           mem_en, mem_we, mem_addr, mem_wdata, owner
  );

  modport slave (
    input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, l_lock, mem_rdata,
    output f_gnt, f_rvalid, f_rdata, f_err, l_gnt, l_rvalid, l_rdata, l_err,
           mem_en, mem_we, mem_addr, mem_wdata, owner
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// Shares one instruction-memory port between CPU fetch (read-only) and the loader/debug port
// (read/write): per-cycle arbitration, loader lock, fetch starvation guard, registered responses.
module imem_port_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int DEPTH_WORDS = 64,
  parameter int MAX_STARVE  = 4
) (
  input  logic clk,
  input  logic rst_n,
  imem_port_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FETCH  = 2'd1;
  localparam logic [1:0] ST_LOAD   = 2'd2;
  localparam logic [1:0] ST_LOCKED = 2'd3;

  localparam logic OWN_FETCH  = 1'b0;
  localparam logic OWN_LOADER = 1'b1;

  localparam int               CNT_W      = $clog2(MAX_STARVE + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(MAX_STARVE);
  localparam logic [ADDR_W-1:0] DEPTH     = ADDR_W'(DEPTH_WORDS);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             last_owner_q, last_owner_d;

  logic              f_rvalid_q, f_rvalid_d;
  logic              f_err_q, f_err_d;
  logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
  logic              l_rvalid_q, l_rvalid_d;
  logic              l_err_q, l_err_d;
  logic [DATA_W-1:0] l_rdata_q, l_rdata_d;

  logic              f_gnt, l_gnt;
  logic              f_bad, l_bad;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  // Misaligned or beyond the last word: still granted, but never touches memory.
  assign f_bad = bus.f_addr[0] | ((bus.f_addr >> 1) >= DEPTH);
  assign l_bad = bus.l_addr[0] | ((bus.l_addr >> 1) >= DEPTH);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (state_q == ST_LOCKED && bus.l_lock) begin
      l_gnt = bus.l_req;
    end else if (bus.f_req && starve_cnt_q == STARVE_MAX) begin
      f_gnt = 1'b1;
    end else if (bus.f_req && bus.l_req) begin
      if (last_owner_q == OWN_LOADER) f_gnt = 1'b1;
      else                            l_gnt = 1'b1;
    end else begin
      f_gnt = bus.f_req;
      l_gnt = bus.l_req;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (f_gnt) begin
      mem_addr = bus.f_addr >> 1;
      mem_en   = ~f_bad;
    end else if (l_gnt) begin
      mem_addr = bus.l_addr >> 1;
      mem_en   = ~l_bad;
      mem_we   = bus.l_we & ~l_bad;
      if (mem_we) mem_wdata = bus.l_wdata;
    end
  end

  always_comb begin
    state_d      = ST_IDLE;
    last_owner_d = last_owner_q;
    starve_cnt_d = starve_cnt_q;

    if (l_gnt && bus.l_lock)                    state_d = ST_LOCKED;
    else if (l_gnt)                             state_d = ST_LOAD;
    else if (f_gnt)                             state_d = ST_FETCH;
    else if (state_q == ST_LOCKED && bus.l_lock) state_d = ST_LOCKED;

    if (f_gnt)      last_owner_d = OWN_FETCH;
    else if (l_gnt) last_owner_d = OWN_LOADER;

    if (!bus.f_req || f_gnt)          starve_cnt_d = '0;
    else if (starve_cnt_q < STARVE_MAX) starve_cnt_d = starve_cnt_q + CNT_W'(1);

    f_rvalid_d = f_gnt;
    f_err_d    = f_gnt & f_bad;
    f_rdata_d  = (f_gnt && !f_bad) ? bus.mem_rdata : '0;
    l_rvalid_d = l_gnt;
    l_err_d    = l_gnt & l_bad;
    l_rdata_d  = (l_gnt && !l_bad && !bus.l_we) ? bus.mem_rdata : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      starve_cnt_q <= '0;
      last_owner_q <= OWN_LOADER;
      f_rvalid_q   <= 1'b0;
      f_err_q      <= 1'b0;
      f_rdata_q    <= '0;
      l_rvalid_q   <= 1'b0;
      l_err_q      <= 1'b0;
      l_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      last_owner_q <= last_owner_d;
      f_rvalid_q   <= f_rvalid_d;
      f_err_q      <= f_err_d;
      f_rdata_q    <= f_rdata_d;
      l_rvalid_q   <= l_rvalid_d;
      l_err_q      <= l_err_d;
      l_rdata_q    <= l_rdata_d;
    end
  end

  // Combinational outputs are forced quiet while reset is held.
  assign bus.f_gnt     = rst_n & f_gnt;
  assign bus.l_gnt     = rst_n & l_gnt;
  assign bus.mem_en    = rst_n & mem_en;
  assign bus.mem_we    = rst_n & mem_we;
  assign bus.mem_addr  = rst_n ? mem_addr  : '0;
  assign bus.mem_wdata = rst_n ? mem_wdata : '0;

  assign bus.f_rvalid = f_rvalid_q;
  assign bus.f_err    = f_err_q;
  assign bus.f_rdata  = f_rdata_q;
  assign bus.l_rvalid = l_rvalid_q;
  assign bus.l_err    = l_err_q;
  assign bus.l_rdata  = l_rdata_q;
  assign bus.owner    = state_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter: memory model, reference memory and a response scoreboard.
module tb_imem_port_arbiter;

  logic clk;
  logic rst_n;

  imem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  imem_port_arbiter #(
    .ADDR_W(16), .DATA_W(16), .DEPTH_WORDS(64), .MAX_STARVE(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory attached to the port, plus an independent reference copy.
  logic [15:0] mem     [64];
  logic [15:0] ref_mem [64];

  assign bus.mem_rdata = mem[bus.mem_addr[5:0]];

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
  end

  typedef struct packed {
    logic        is_f;
    logic [15:0] data;
    logic        err;
  } resp_t;

  resp_t sb[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic bit addr_ok(input logic [15:0] a);
    return !a[0] && ((a >> 1) < 16'd64);
  endfunction

  task automatic check_resp(input string tag);
    resp_t r;
    bit    has;
    r   = '0;
    has = (sb.size() > 0);
    if (has) r = sb.pop_front();
    check({tag, ".f_rvalid"}, bus.f_rvalid, has && r.is_f);
    check({tag, ".l_rvalid"}, bus.l_rvalid, has && !r.is_f);
    if (has && r.is_f) begin
      check({tag, ".f_rdata"}, bus.f_rdata, r.data);
      check({tag, ".f_err"},   bus.f_err,   r.err);
    end else if (has) begin
      check({tag, ".l_rdata"}, bus.l_rdata, r.data);
      check({tag, ".l_err"},   bus.l_err,   r.err);
    end
  endtask

  task automatic drive(input logic fr, input logic [15:0] fa, input logic lr, input logic lw,
                       input logic lk, input logic [15:0] la, input logic [15:0] ld);
    bus.f_req   = fr;
    bus.f_addr  = fa;
    bus.l_req   = lr;
    bus.l_we    = lw;
    bus.l_lock  = lk;
    bus.l_addr  = la;
    bus.l_wdata = ld;
  endtask

  // One clock cycle: drive at negedge, check grant/memory strobes, then check the response.
  task automatic step(input string tag, input logic fr, input logic [15:0] fa,
                      input logic lr, input logic lw, input logic lk,
                      input logic [15:0] la, input logic [15:0] ld,
                      input logic ef, input logic el);
    logic        ok;
    logic        exp_en, exp_we;
    logic [15:0] exp_addr;
    resp_t       r;
    drive(fr, fa, lr, lw, lk, la, ld);
    #1;
    check({tag, ".f_gnt"}, bus.f_gnt, ef);
    check({tag, ".l_gnt"}, bus.l_gnt, el);
    exp_en = 1'b0; exp_we = 1'b0; exp_addr = 16'h0;
    if (ef) begin
      ok       = addr_ok(fa);
      exp_addr = fa >> 1;
      exp_en   = ok;
      r.is_f   = 1'b1;
      r.err    = !ok;
      r.data   = ok ? ref_mem[fa[6:1]] : 16'h0;
      sb.push_back(r);
    end else if (el) begin
      ok       = addr_ok(la);
      exp_addr = la >> 1;
      exp_en   = ok;
      exp_we   = ok && lw;
      r.is_f   = 1'b0;
      r.err    = !ok;
      r.data   = (ok && !lw) ? ref_mem[la[6:1]] : 16'h0;
      sb.push_back(r);
      if (ok && lw) ref_mem[la[6:1]] = ld;
    end
    check({tag, ".mem_en"},   bus.mem_en,   exp_en);
    check({tag, ".mem_we"},   bus.mem_we,   exp_we);
    check({tag, ".mem_addr"}, bus.mem_addr, exp_addr);
    if (exp_we) check({tag, ".mem_wdata"}, bus.mem_wdata, ld);
    @(posedge clk);
    @(negedge clk);
    check_resp(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 16'h0310 + 16'(i);
      ref_mem[i] = 16'h0310 + 16'(i);
    end

    // Reset state, with a fetch request present that must not be granted.
    rst_n = 1'b0;
    drive(1'b1, 16'h0004, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.f_gnt",    bus.f_gnt,    1'b0);
    check("rst.mem_en",   bus.mem_en,   1'b0);
    check("rst.owner",    bus.owner,    2'b00);
    check("rst.f_rvalid", bus.f_rvalid, 1'b0);
    check("rst.l_rvalid", bus.l_rvalid, 1'b0);
    bus.f_req = 1'b0;
    rst_n     = 1'b1;

    // Fetch only: word 2.
    step("fetch2", 1, 16'h0004, 0, 0, 0, 16'h0, 16'h0, 1, 0);
    check("fetch2.owner", bus.owner, 2'b01);

    // Reset asserted in the middle of a granted loader read.
    drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0008, 16'h0);
    #1;
    check("midrst.l_gnt_pre", bus.l_gnt, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst.l_gnt",    bus.l_gnt,    1'b0);
    check("midrst.mem_en",   bus.mem_en,   1'b0);
    check("midrst.mem_addr", bus.mem_addr, 16'h0);
    check("midrst.owner",    bus.owner,    2'b00);
    check("midrst.f_rvalid", bus.f_rvalid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("midrst.l_rvalid_hold", bus.l_rvalid, 1'b0);
    rst_n = 1'b1;
    step("postrst_idle", 0, 16'h0, 0, 0, 0, 16'h0, 16'h0, 0, 0);

    // Contention after reset: fetch wins first, then alternate.
    do_reset();
    step("rr0", 1, 16'h0006, 1, 0, 0, 16'h0008, 16'h0, 1, 0);
    step("rr1", 1, 16'h0006, 1, 0, 0, 16'h0008, 16'h0, 0, 1);
    step("rr2", 1, 16'h0006, 1, 0, 0, 16'h0008, 16'h0, 1, 0);
    step("rr3", 1, 16'h0006, 1, 0, 0, 16'h0008, 16'h0, 0, 1);

    // Lock: make fetch the last owner, then the loader locks for 10 cycles.
    step("prelock", 1, 16'h0000, 0, 0, 0, 16'h0, 16'h0, 1, 0);
    for (int i = 0; i < 10; i++)
      step($sformatf("lock%0d", i), 1, 16'h0002, 1, 0, 1, 16'h0008, 16'h0, 0, 1);
    check("lock.starve_cnt", dut.starve_cnt_q, 3'd4);
    check("lock.owner",      bus.owner,        2'b11);
    step("unlock", 1, 16'h0002, 1, 0, 0, 16'h0008, 16'h0, 1, 0);
    check("unlock.owner",      bus.owner,        2'b01);
    check("unlock.starve_cnt", dut.starve_cnt_q, 3'd0);

    // Loader write and readback, then fetch of the same word.
    step("lwr",  0, 16'h0,    1, 1, 0, 16'h000A, 16'hBEEF, 0, 1);
    check("lwr.owner", bus.owner, 2'b10);
    step("lrd",  0, 16'h0,    1, 0, 0, 16'h000A, 16'h0,    0, 1);
    step("frd",  1, 16'h000A, 0, 0, 0, 16'h0,    16'h0,    1, 0);
    check("frd.mem", mem[5], 16'hBEEF);

    // Address boundaries and errors.
    step("f_last",  1, 16'h007E, 0, 0, 0, 16'h0,    16'h0,    1, 0);
    step("f_odd",   1, 16'h0003, 0, 0, 0, 16'h0,    16'h0,    1, 0);
    step("f_range", 1, 16'h0080, 0, 0, 0, 16'h0,    16'h0,    1, 0);
    step("l_range", 0, 16'h0,    1, 1, 0, 16'h0080, 16'h1234, 0, 1);
    step("l_odd",   0, 16'h0,    1, 0, 0, 16'h0005, 16'h0,    0, 1);
    step("l_bwr",   0, 16'h0,    1, 1, 0, 16'h007E, 16'hA55A, 0, 1);
    step("f_bwr",   1, 16'h007E, 0, 0, 0, 16'h0,    16'h0,    1, 0);
    step("idle",    0, 16'h0,    0, 0, 0, 16'h0,    16'h0,    0, 0);
    check("idle.owner", bus.owner, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
